// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline definitions: control FSM encoding, register-number width
// and the writeback-source encodings also used by forwarding and writeback.
package pipe_ctrl_pkg;

   localparam int REG_W = 5;

   // Writeback source select encodings.
   localparam logic [1:0] WDSEL_ALU = 2'd0;
   localparam logic [1:0] WDSEL_DM  = 2'd1;
   localparam logic [1:0] WDSEL_PC4 = 2'd2;

   // Pipeline control FSM: free running or waiting on data memory.
   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } pipe_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline datapath and the pipeline controller.
// Handshake: the MEM stage raises mem_req; the access completes in the cycle
// mem_ready is high. Until then the controller freezes every pipeline register.
interface pipe_ctrl_if #(parameter int CNT_W = 16);
   import pipe_ctrl_pkg::*;

   logic [REG_W-1:0] id_rR1;
   logic [REG_W-1:0] id_rR2;
   logic             id_re1;
   logic             id_re2;
   logic             ex_RFWr;
   logic [1:0]       ex_WDSel;
   logic [REG_W-1:0] ex_wR;
   logic             ex_br_taken;
   logic             mem_req;
   logic             mem_ready;

   logic             pc_we;
   logic             if_id_we;
   logic             id_ex_we;
   logic             ex_mem_we;
   logic             mem_wb_we;
   logic             ID_running;
   logic             EX_running;
   logic             MEM_running;
   logic             WB_running;
   logic             mem_wait;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   // Datapath side: supplies hazard information, consumes enables and flags.
   modport master (
      output id_rR1, id_rR2, id_re1, id_re2, ex_RFWr, ex_WDSel, ex_wR,
             ex_br_taken, mem_req, mem_ready,
      input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
             ID_running, EX_running, MEM_running, WB_running,
             mem_wait, stall_cnt, flush_cnt
   );

   // Controller side.
   modport slave (
      input  id_rR1, id_rR2, id_re1, id_re2, ex_RFWr, ex_WDSel, ex_wR,
             ex_br_taken, mem_req, mem_ready,
      output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
             ID_running, EX_running, MEM_running, WB_running,
             mem_wait, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational hazard decode: load-use, taken branch and memory stall.
module hazard_detect #(
   parameter logic [1:0] WDSEL_DM = pipe_ctrl_pkg::WDSEL_DM
) (
   input  logic                           id_running,
   input  logic                           ex_running,
   input  logic                           mem_running,
   input  logic [pipe_ctrl_pkg::REG_W-1:0] id_rR1,
   input  logic [pipe_ctrl_pkg::REG_W-1:0] id_rR2,
   input  logic                           id_re1,
   input  logic                           id_re2,
   input  logic                           ex_RFWr,
   input  logic [1:0]                     ex_WDSel,
   input  logic [pipe_ctrl_pkg::REG_W-1:0] ex_wR,
   input  logic                           ex_br_taken,
   input  logic                           mem_req,
   input  logic                           mem_ready,
   output logic                           load_use,
   output logic                           br,
   output logic                           mem_stall
);

   logic src_match;

   // A live source operand matches the EX destination; x0 never matches.
   assign src_match = (id_re1 & (id_rR1 == ex_wR)) | (id_re2 & (id_rR2 == ex_wR));

   assign load_use  = id_running & ex_running & ex_RFWr & (ex_WDSel == WDSEL_DM)
                    & (ex_wR != '0) & src_match;
   assign br        = ex_running & ex_br_taken;
   assign mem_stall = mem_running & mem_req & ~mem_ready;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stage-valid flags, register write enables,
// memory-wait FSM and saturating stall/flush counters.
module pipe_ctrl #(
   parameter int         CNT_W    = 16,
   parameter logic [1:0] WDSEL_DM = pipe_ctrl_pkg::WDSEL_DM
) (
   input  logic      clk,
   input  logic      rst_n,
   pipe_ctrl_if.slave bus
);
   import pipe_ctrl_pkg::*;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   pipe_state_e      state, state_nxt;
   logic             load_use, br, mem_stall;
   logic             id_run, ex_run, mem_run, wb_run;
   logic             id_run_nxt, ex_run_nxt, mem_run_nxt, wb_run_nxt;
   logic [4:0]       we;   // {pc, if_id, id_ex, ex_mem, mem_wb}
   logic             stall_inc, flush_inc;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   hazard_detect #(.WDSEL_DM(WDSEL_DM)) u_hazard (
      .id_running  (id_run),
      .ex_running  (ex_run),
      .mem_running (mem_run),
      .id_rR1      (bus.id_rR1),
      .id_rR2      (bus.id_rR2),
      .id_re1      (bus.id_re1),
      .id_re2      (bus.id_re2),
      .ex_RFWr     (bus.ex_RFWr),
      .ex_WDSel    (bus.ex_WDSel),
      .ex_wR       (bus.ex_wR),
      .ex_br_taken (bus.ex_br_taken),
      .mem_req     (bus.mem_req),
      .mem_ready   (bus.mem_ready),
      .load_use    (load_use),
      .br          (br),
      .mem_stall   (mem_stall)
   );

   // Prioritised control decode: memory stall, then flush, then load-use bubble.
   always_comb begin
      state_nxt   = state;
      we          = 5'b11111;
      id_run_nxt  = 1'b1;
      ex_run_nxt  = id_run;
      mem_run_nxt = ex_run;
      wb_run_nxt  = mem_run;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;

      case (state)
         ST_RUN:      if (mem_stall)     state_nxt = ST_MEM_WAIT;
         ST_MEM_WAIT: if (bus.mem_ready) state_nxt = ST_RUN;
         default:                        state_nxt = ST_RUN;
      endcase

      if (mem_stall) begin
         // Freeze everything; pending flush/bubble re-evaluates once memory answers.
         we          = 5'b00000;
         id_run_nxt  = id_run;
         ex_run_nxt  = ex_run;
         mem_run_nxt = mem_run;
         wb_run_nxt  = wb_run;
         stall_inc   = 1'b1;
      end else if (br) begin
         // Kill the two wrong-path instructions in IF/ID and ID/EX.
         id_run_nxt  = 1'b0;
         ex_run_nxt  = 1'b0;
         flush_inc   = 1'b1;
      end else if (load_use) begin
         // Hold PC and IF/ID, insert one bubble into EX.
         we          = 5'b00111;
         id_run_nxt  = id_run;
         ex_run_nxt  = 1'b0;
         stall_inc   = 1'b1;
      end
   end

   // FSM state and stage-valid flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_RUN;
         id_run  <= 1'b0;
         ex_run  <= 1'b0;
         mem_run <= 1'b0;
         wb_run  <= 1'b0;
      end else begin
         state   <= state_nxt;
         id_run  <= id_run_nxt;
         ex_run  <= ex_run_nxt;
         mem_run <= mem_run_nxt;
         wb_run  <= wb_run_nxt;
      end
   end

   // Saturating performance counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
         if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_ONE;
      end
   end

   assign bus.pc_we       = we[4];
   assign bus.if_id_we    = we[3];
   assign bus.id_ex_we    = we[2];
   assign bus.ex_mem_we   = we[1];
   assign bus.mem_wb_we   = we[0];
   assign bus.ID_running  = id_run;
   assign bus.EX_running  = ex_run;
   assign bus.MEM_running = mem_run;
   assign bus.WB_running  = wb_run;
   assign bus.mem_wait    = (state == ST_MEM_WAIT);
   assign bus.stall_cnt   = stall_cnt;
   assign bus.flush_cnt   = flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed hazard scenarios plus random traffic,
// checked cycle by cycle against a stage-occupancy reference model.
module tb_pipe_ctrl;

   localparam int CNT_W   = 16;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   localparam int OUT_W   = 5 + 4 + 1 + 2 * CNT_W;

   typedef struct {
      logic       rst_n;
      logic [4:0] rR1, rR2;
      logic       re1, re2;
      logic       RFWr;
      logic [1:0] WDSel;
      logic [4:0] wR;
      logic       br_taken;
      logic       mem_req, mem_ready;
   } stim_t;

   logic clk;
   logic rst_n;

   pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

   pipe_ctrl #(.CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [OUT_W-1:0] exp_q[$];
   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // Reference model: which stages hold a live instruction, plus counters.
   bit occ[4], occ_n[4];          // 0=ID 1=EX 2=MEM 3=WB
   bit wt, wt_n;
   int scnt, scnt_n, fcnt, fcnt_n;

   function automatic int sat_inc(input int v);
      return (v >= CNT_MAX) ? CNT_MAX : v + 1;
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s.rst_n = 1'b1; s.rR1 = 5'd0; s.rR2 = 5'd0; s.re1 = 1'b0; s.re2 = 1'b0;
      s.RFWr = 1'b0; s.WDSel = 2'd0; s.wR = 5'd0; s.br_taken = 1'b0;
      s.mem_req = 1'b0; s.mem_ready = 1'b1;
      return s;
   endfunction

   task automatic apply(input stim_t s);
      rst_n           = s.rst_n;
      bus.id_rR1      = s.rR1;
      bus.id_rR2      = s.rR2;
      bus.id_re1      = s.re1;
      bus.id_re2      = s.re2;
      bus.ex_RFWr     = s.RFWr;
      bus.ex_WDSel    = s.WDSel;
      bus.ex_wR       = s.wR;
      bus.ex_br_taken = s.br_taken;
      bus.mem_req     = s.mem_req;
      bus.mem_ready   = s.mem_ready;
   endtask

   task automatic commit();
      occ = occ_n; wt = wt_n; scnt = scnt_n; fcnt = fcnt_n;
   endtask

   // Expected outputs for the current cycle, and the model state after the edge.
   task automatic model_eval(input stim_t s);
      logic [4:0] en;
      bit ms, bv, lu;
      en = 5'b11111;
      if (!s.rst_n) begin
         for (int i = 0; i < 4; i++) begin occ[i] = 0; occ_n[i] = 0; end
         wt = 0; wt_n = 0; scnt = 0; scnt_n = 0; fcnt = 0; fcnt_n = 0;
      end else begin
         ms = occ[2] && s.mem_req && !s.mem_ready;
         bv = occ[1] && s.br_taken;
         lu = occ[0] && occ[1] && s.RFWr && (s.WDSel == 2'd1) && (s.wR != 0) &&
              ((s.re1 && s.rR1 == s.wR) || (s.re2 && s.rR2 == s.wR));
         wt_n = wt ? !s.mem_ready : ms;
         scnt_n = scnt; fcnt_n = fcnt;
         if (ms) begin
            en = 5'b00000;
            occ_n = occ;
            scnt_n = sat_inc(scnt);
         end else if (bv) begin
            occ_n[0] = 0; occ_n[1] = 0; occ_n[2] = occ[1]; occ_n[3] = occ[2];
            fcnt_n = sat_inc(fcnt);
         end else if (lu) begin
            en = 5'b00111;
            occ_n[0] = occ[0]; occ_n[1] = 0; occ_n[2] = occ[1]; occ_n[3] = occ[2];
            scnt_n = sat_inc(scnt);
         end else begin
            occ_n[0] = 1; occ_n[1] = occ[0]; occ_n[2] = occ[1]; occ_n[3] = occ[2];
         end
      end
      exp_q.push_back({en, occ[0], occ[1], occ[2], occ[3], wt,
                       CNT_W'(scnt), CNT_W'(fcnt)});
   endtask

   // ---------------- driver tasks ----------------
   task automatic step(input stim_t s);
      @(posedge clk);
      #1;
      commit();
      apply(s);
      model_eval(s);
   endtask

   // Assert reset in the middle of a cycle and check the clear happens at once.
   task automatic step_rst_mid(input stim_t s);
      @(posedge clk);
      #1;
      commit();
      apply(s);
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus.ID_running, bus.EX_running, bus.MEM_running, bus.WB_running,
           bus.mem_wait} !== 5'b0 || bus.stall_cnt !== '0 || bus.flush_cnt !== '0) begin
         n_fail++;
         $display("FAIL async_reset flags/wait=%b stall=%h flush=%h required all zero",
                  {bus.ID_running, bus.EX_running, bus.MEM_running, bus.WB_running,
                   bus.mem_wait}, bus.stall_cnt, bus.flush_cnt);
      end
      s.rst_n = 1'b0;
      model_eval(s);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [OUT_W-1:0] exp_v, act_v;
      cyc++;
      if (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         act_v = {bus.pc_we, bus.if_id_we, bus.id_ex_we, bus.ex_mem_we, bus.mem_wb_we,
                  bus.ID_running, bus.EX_running, bus.MEM_running, bus.WB_running,
                  bus.mem_wait, bus.stall_cnt, bus.flush_cnt};
         n_cmp++;
         if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL outputs cyc=%0d we/run/wait act=%b exp=%b stall act=%h exp=%h flush act=%h exp=%h",
                     cyc, act_v[OUT_W-1 -: 10], exp_v[OUT_W-1 -: 10],
                     act_v[2*CNT_W-1 -: CNT_W], exp_v[2*CNT_W-1 -: CNT_W],
                     act_v[CNT_W-1:0], exp_v[CNT_W-1:0]);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      stim_t s;
      for (int i = 0; i < 4; i++) begin occ_n[i] = 0; end
      wt_n = 0; scnt_n = 0; fcnt_n = 0;
      s = idle();
      s.rst_n = 1'b0;
      apply(s);

      // Reset held, then release with no hazards: flags fill over four edges.
      repeat (3) step(s);
      s = idle();
      repeat (6) step(s);

      // Load-use on rR2 with a DM writeback: one bubble.
      s = idle(); s.RFWr = 1; s.WDSel = 2'd1; s.wR = 5'd5;
      s.re1 = 1; s.rR1 = 5'd2; s.re2 = 1; s.rR2 = 5'd5;
      step(s);
      s.RFWr = 0;
      repeat (4) step(s);

      // Same with an x0 destination: no stall.
      s = idle(); s.RFWr = 1; s.WDSel = 2'd1; s.wR = 5'd0;
      s.re1 = 1; s.rR1 = 5'd0; s.re2 = 1; s.rR2 = 5'd0;
      step(s);
      s = idle();
      repeat (4) step(s);

      // Branch and load-use together: flush wins.
      s = idle(); s.RFWr = 1; s.WDSel = 2'd1; s.wR = 5'd7;
      s.re1 = 1; s.rR1 = 5'd7; s.br_taken = 1;
      step(s);
      s = idle();
      repeat (4) step(s);

      // Memory wait of three cycles with a branch held throughout.
      s = idle(); s.mem_req = 1; s.mem_ready = 0; s.br_taken = 1;
      repeat (3) step(s);
      s.mem_ready = 1;
      step(s);
      s = idle();
      repeat (5) step(s);

      // Reset in the second MEM_WAIT cycle.
      s = idle(); s.mem_req = 1; s.mem_ready = 0;
      repeat (2) step(s);
      step_rst_mid(s);
      s = idle(); s.rst_n = 1'b0;
      step(s);
      s = idle();
      repeat (6) step(s);

      // Random traffic with small register numbers to provoke matches.
      for (int n = 0; n < 3000; n++) begin
         s.rst_n     = ($urandom_range(0, 299) != 0);
         s.rR1       = 5'($urandom_range(0, 3));
         s.rR2       = 5'($urandom_range(0, 3));
         s.re1       = 1'($urandom_range(0, 1));
         s.re2       = 1'($urandom_range(0, 1));
         s.RFWr      = 1'($urandom_range(0, 1));
         s.WDSel     = 2'($urandom_range(0, 3));
         s.wR        = 5'($urandom_range(0, 3));
         s.br_taken  = ($urandom_range(0, 9) == 0);
         s.mem_req   = ($urandom_range(0, 3) == 0);
         s.mem_ready = ($urandom_range(0, 2) != 0);
         step(s);
      end

      // Long memory stall to drive stall_cnt into saturation.
      s = idle();
      repeat (6) step(s);
      s.mem_req = 1; s.mem_ready = 0;
      repeat (CNT_MAX + 5) step(s);
      s = idle();
      repeat (3) step(s);

      // Drain the scoreboard with a bounded wait.
      repeat (3) @(negedge clk);
      #1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain pending=%0d required 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
